// File: rtl/wam_game_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wam_pkg
// Brief   : Shared state, game-mode and difficulty encodings for whack-a-mole.
// Revision: 1.0
// ============================================================================
package wam_pkg;

    localparam logic [1:0] c_ST_SETUP     = 2'd0;
    localparam logic [1:0] c_ST_PLAY      = 2'd1;
    localparam logic [1:0] c_ST_GAME_OVER = 2'd2;
    localparam logic [1:0] c_ST_RESTART   = 2'd3;

    localparam logic [3:0] c_GM_NORMAL     = 4'b0001;
    localparam logic [3:0] c_GM_TIMED      = 4'b0010;
    localparam logic [3:0] c_GM_DEATHMATCH = 4'b0100;
    localparam logic [3:0] c_GM_CONTINUITY = 4'b1000;

    localparam logic [3:0] c_DIFF_EASY   = 4'b0001;
    localparam logic [3:0] c_DIFF_MEDIUM = 4'b0010;
    localparam logic [3:0] c_DIFF_HARD   = 4'b0100;
    localparam logic [3:0] c_DIFF_EXPERT = 4'b1000;

    localparam int c_DEF_NORMAL_HITS = 25;
    localparam int c_DEF_EXT_HITS    = 50;

    typedef enum logic [1:0] {
        MODE_NORMAL     = 2'd0,
        MODE_TIMED      = 2'd1,
        MODE_DEATHMATCH = 2'd2,
        MODE_CONTINUITY = 2'd3
    } mode_t;

    // Anything that is not exactly one of the defined one-hot codes plays as normal.
    function automatic mode_t decode_mode(input logic [3:0] gm);
        mode_t m;
        case (gm)
            c_GM_TIMED:      m = MODE_TIMED;
            c_GM_DEATHMATCH: m = MODE_DEATHMATCH;
            c_GM_CONTINUITY: m = MODE_CONTINUITY;
            default:         m = MODE_NORMAL;
        endcase
        return m;
    endfunction

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wam_window_tracker.sv
`default_nettype none
// ============================================================================
// Module  : wam_window_tracker
// Brief   : Light-window edge detection and once-per-window hit/miss/close pulses.
// Revision: 1.0
// ============================================================================
module wam_window_tracker (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       light_active,
    input  logic [3:0] light_coord,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       hit,
    output logic       miss,
    output logic       close
);

    logic r_light_d;
    logic r_in_window;
    logic r_hit_taken;
    logic w_open;
    logic w_live;
    logic w_taken;

    // A window only exists if its rising edge was seen while enabled, so a light
    // already lit when play begins is ignored until the next one.
    assign w_open  = enable & light_active & ~r_light_d;
    assign close   = enable & r_in_window & ~light_active;
    // The closing cycle still belongs to the window so a last-moment key scores.
    assign w_live  = enable & (w_open | r_in_window);
    assign w_taken = r_hit_taken & ~w_open;
    assign hit     = w_live & key_valid & (key_code == light_coord) & ~w_taken;
    assign miss    = close & ~w_taken & ~hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_light_d   <= 1'b0;
            r_in_window <= 1'b0;
            r_hit_taken <= 1'b0;
        end else begin
            r_light_d   <= light_active;
            r_hit_taken <= w_open ? hit : (r_hit_taken | hit);
            if (!enable)
                r_in_window <= 1'b0;
            else if (w_open)
                r_in_window <= 1'b1;
            else if (close)
                r_in_window <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wam_game_controller.sv
`default_nettype none
// ============================================================================
// Module  : wam_game_controller
// Brief   : Game FSM, scoring, lives and level control; WAM_STREAK_EN adds best_streak.
// Revision: 1.0
// ============================================================================
module wam_game_controller
    import wam_pkg::*;
#(
    parameter int NORMAL_HITS = c_DEF_NORMAL_HITS,
    parameter int EXT_HITS    = c_DEF_EXT_HITS,
    parameter int DM_LIVES    = 1,
    parameter int LEVEL_STEP  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       play,
    input  logic [3:0] gamemode,
    input  logic [3:0] difficulty,
    input  logic       ext_game,
    input  logic       light_active,
    input  logic [3:0] light_coord,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       time_up,
    output logic       load_seed,
    output logic       start_game,
    output logic       clear_n,
    output logic [1:0] state,
    output logic [5:0] total_points,
    output logic [5:0] light_flicks,
    output logic [5:0] max_hits,
    output logic [1:0] lives_left,
    output logic [3:0] level_diff,
    output logic       game_over
`ifdef WAM_STREAK_EN
    ,
    output logic [5:0] best_streak
`endif
);

    localparam logic [5:0] c_NORMAL_MAX = 6'(NORMAL_HITS);
    localparam logic [5:0] c_EXT_MAX    = 6'(EXT_HITS);
    localparam logic [1:0] c_DM_LIVES   = 2'(DM_LIVES);
    localparam logic [7:0] c_LVL1       = 8'(LEVEL_STEP);
    localparam logic [7:0] c_LVL2       = 8'(2 * LEVEL_STEP);
    localparam logic [7:0] c_LVL3       = 8'(3 * LEVEL_STEP);
    localparam logic [5:0] c_SAT        = 6'd63;

    logic       r_play_q;
    logic       r_play_qq;
    logic       w_play_rise;
    logic [1:0] r_state;
    mode_t      r_mode;
    logic [3:0] r_diff;
    logic [5:0] r_points;
    logic [5:0] r_flicks;
    logic [5:0] r_max_hits;
    logic [1:0] r_lives;
    logic [3:0] r_level_diff;
    logic [3:0] w_cont_level;
    logic [7:0] w_fl8;
    logic       w_in_play;
    logic       w_game_end;
    logic       w_hit;
    logic       w_miss;
    logic       w_close;

    assign w_play_rise = r_play_q & ~r_play_qq;
    assign w_in_play   = (r_state == c_ST_PLAY);
    assign w_game_end  = (r_flicks == r_max_hits)
                       || ((r_mode == MODE_DEATHMATCH) && (r_lives == 2'd0))
                       || ((r_mode == MODE_TIMED) && time_up);

    wam_window_tracker u_tracker (
        .clk          (clk),
        .reset        (reset),
        .enable       (w_in_play),
        .light_active (light_active),
        .light_coord  (light_coord),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .hit          (w_hit),
        .miss         (w_miss),
        .close        (w_close)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_play_q  <= 1'b0;
            r_play_qq <= 1'b0;
            r_state   <= c_ST_SETUP;
        end else begin
            r_play_q  <= play;
            r_play_qq <= r_play_q;
            case (r_state)
                c_ST_SETUP:     if (w_play_rise) r_state <= c_ST_RESTART;
                c_ST_RESTART:   r_state <= c_ST_PLAY;
                c_ST_PLAY: begin
                    if (w_play_rise)
                        r_state <= c_ST_RESTART;
                    else if (w_game_end)
                        r_state <= c_ST_GAME_OVER;
                end
                c_ST_GAME_OVER: if (w_play_rise) r_state <= c_ST_RESTART;
                default:        r_state <= c_ST_SETUP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mode     <= MODE_NORMAL;
            r_diff     <= 4'd0;
            r_points   <= 6'd0;
            r_flicks   <= 6'd0;
            r_max_hits <= 6'd0;
            r_lives    <= 2'd0;
        end else if (r_state == c_ST_RESTART) begin
            r_mode     <= decode_mode(gamemode);
            r_diff     <= difficulty;
            r_points   <= 6'd0;
            r_flicks   <= 6'd0;
            r_max_hits <= ext_game ? c_EXT_MAX : c_NORMAL_MAX;
            r_lives    <= (decode_mode(gamemode) == MODE_DEATHMATCH) ? c_DM_LIVES : 2'd0;
        end else if (w_in_play) begin
            if (w_hit && (r_points != c_SAT))
                r_points <= r_points + 6'd1;
            if (w_close && (r_flicks != c_SAT))
                r_flicks <= r_flicks + 6'd1;
            if (w_miss && (r_mode == MODE_DEATHMATCH) && (r_lives != 2'd0))
                r_lives <= r_lives - 2'd1;
        end
    end

    // Continuity level follows the registered flick count, so it lags by one cycle.
    assign w_fl8 = {2'b00, r_flicks};

    always_comb begin
        w_cont_level = 4'b0001;
        if (w_fl8 >= c_LVL3)
            w_cont_level = 4'b1000;
        else if (w_fl8 >= c_LVL2)
            w_cont_level = 4'b0100;
        else if (w_fl8 >= c_LVL1)
            w_cont_level = 4'b0010;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_level_diff <= c_DIFF_MEDIUM;
        else if (r_mode == MODE_CONTINUITY)
            r_level_diff <= w_cont_level;
        else
            r_level_diff <= is_onehot4(r_diff) ? r_diff : c_DIFF_MEDIUM;
    end

`ifdef WAM_STREAK_EN
    logic [5:0] r_cur_streak;
    logic [5:0] r_best_streak;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cur_streak  <= 6'd0;
            r_best_streak <= 6'd0;
        end else if (r_state == c_ST_RESTART) begin
            r_cur_streak  <= 6'd0;
            r_best_streak <= 6'd0;
        end else begin
            if (w_hit && (r_cur_streak != c_SAT))
                r_cur_streak <= r_cur_streak + 6'd1;
            else if (w_miss)
                r_cur_streak <= 6'd0;
            if (r_cur_streak > r_best_streak)
                r_best_streak <= r_cur_streak;
        end
    end

    assign best_streak = r_best_streak;
`endif

    assign load_seed    = (r_state == c_ST_SETUP);
    assign start_game   = w_in_play;
    assign clear_n      = (r_state != c_ST_RESTART);
    assign game_over    = (r_state == c_ST_GAME_OVER);
    assign state        = r_state;
    assign total_points = r_points;
    assign light_flicks = r_flicks;
    assign max_hits     = r_max_hits;
    assign lives_left   = r_lives;
    assign level_diff   = r_level_diff;

endmodule
`default_nettype wire

// File: tb/tb_wam_game_controller.sv
`default_nettype none
// Directed bench for wam_game_controller: vector table for in-window scoring,
// hand sequences for game flow, modes and level progression.
module tb_wam_game_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       play;
    logic [3:0] gamemode;
    logic [3:0] difficulty;
    logic       ext_game;
    logic       light_active;
    logic [3:0] light_coord;
    logic       key_valid;
    logic [3:0] key_code;
    logic       time_up;
    logic       load_seed;
    logic       start_game;
    logic       clear_n;
    logic [1:0] state;
    logic [5:0] total_points;
    logic [5:0] light_flicks;
    logic [5:0] max_hits;
    logic [1:0] lives_left;
    logic [3:0] level_diff;
    logic       game_over;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wam_game_controller dut (
        .clk          (clk),
        .reset        (reset),
        .play         (play),
        .gamemode     (gamemode),
        .difficulty   (difficulty),
        .ext_game     (ext_game),
        .light_active (light_active),
        .light_coord  (light_coord),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .time_up      (time_up),
        .load_seed    (load_seed),
        .start_game   (start_game),
        .clear_n      (clear_n),
        .state        (state),
        .total_points (total_points),
        .light_flicks (light_flicks),
        .max_hits     (max_hits),
        .lives_left   (lives_left),
        .level_diff   (level_diff),
        .game_over    (game_over)
    );

    typedef struct {
        logic       la;
        logic [3:0] lc;
        logic       kv;
        logic [3:0] kc;
        int         pts;
        int         fl;
    } vec_t;

    vec_t vt [14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_state(input logic [1:0] s, input int limit, input string name);
        int n;
        n = 0;
        while ((state != s) && (n < limit)) begin
            tick();
            n++;
        end
        total++;
        if (state != s) begin
            bad++;
            $display("FAIL %s: state %0d expected %0d within %0d cycles", name, state, s, limit);
        end
    endtask

    task automatic start_new(input logic [3:0] gm, input logic ext, input string name);
        gamemode = gm;
        ext_game = ext;
        play     = 1'b1;
        wait_state(2'd3, 6, {name, " reach RESTART"});
        chk({name, " clear_n in RESTART"}, int'(clear_n), 0);
        play = 1'b0;
        tick();
        chk({name, " enter PLAY"}, int'(state), 1);
        chk({name, " clear_n in PLAY"}, int'(clear_n), 1);
    endtask

    task automatic window(input logic [3:0] coord, input logic press);
        light_active = 1'b1;
        light_coord  = coord;
        key_valid    = press;
        key_code     = coord;
        tick();
        light_active = 1'b0;
        key_valid    = 1'b0;
        tick();
    endtask

    initial begin
        vt[0]  = '{1'b1, 4'd5, 1'b0, 4'd0, 0, 0};
        vt[1]  = '{1'b1, 4'd5, 1'b1, 4'd5, 1, 0};
        vt[2]  = '{1'b1, 4'd5, 1'b1, 4'd5, 1, 0};
        vt[3]  = '{1'b1, 4'd5, 1'b1, 4'd3, 1, 0};
        vt[4]  = '{1'b0, 4'd5, 1'b0, 4'd0, 1, 1};
        vt[5]  = '{1'b0, 4'd5, 1'b1, 4'd5, 1, 1};
        vt[6]  = '{1'b1, 4'd9, 1'b0, 4'd0, 1, 1};
        vt[7]  = '{1'b1, 4'd9, 1'b1, 4'd2, 1, 1};
        vt[8]  = '{1'b0, 4'd9, 1'b0, 4'd0, 1, 2};
        vt[9]  = '{1'b1, 4'd7, 1'b1, 4'd7, 2, 2};
        vt[10] = '{1'b0, 4'd7, 1'b0, 4'd0, 2, 3};
        vt[11] = '{1'b1, 4'd4, 1'b0, 4'd0, 2, 3};
        vt[12] = '{1'b0, 4'd4, 1'b1, 4'd4, 3, 4};
        vt[13] = '{1'b0, 4'd4, 1'b0, 4'd0, 3, 4};

        reset        = 1'b0;
        play         = 1'b0;
        gamemode     = 4'b0001;
        difficulty   = 4'b0100;
        ext_game     = 1'b0;
        light_active = 1'b0;
        light_coord  = 4'd0;
        key_valid    = 1'b0;
        key_code     = 4'd0;
        time_up      = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();

        chk("reset state", int'(state), 0);
        chk("reset points", int'(total_points), 0);
        chk("reset flicks", int'(light_flicks), 0);
        chk("reset max_hits", int'(max_hits), 0);
        chk("reset lives", int'(lives_left), 0);
        chk("reset level_diff", int'(level_diff), 2);
        chk("reset game_over", int'(game_over), 0);
        chk("reset start_game", int'(start_game), 0);
        chk("reset load_seed", int'(load_seed), 1);
        chk("reset clear_n", int'(clear_n), 1);

        // Normal game, then scoring vectors inside one play session.
        start_new(4'b0001, 1'b0, "normal");
        chk("normal start_game", int'(start_game), 1);
        chk("normal load_seed", int'(load_seed), 0);
        chk("normal max_hits", int'(max_hits), 25);
        tick();
        chk("normal level_diff latched", int'(level_diff), 4);

        for (int i = 0; i < 14; i++) begin
            light_active = vt[i].la;
            light_coord  = vt[i].lc;
            key_valid    = vt[i].kv;
            key_code     = vt[i].kc;
            tick();
            chk($sformatf("vec%0d points", i), int'(total_points), vt[i].pts);
            chk($sformatf("vec%0d flicks", i), int'(light_flicks), vt[i].fl);
            chk($sformatf("vec%0d state", i), int'(state), 1);
        end
        key_valid = 1'b0;

        // Mid-PLAY restart clears counters, then a full 25-hit game.
        start_new(4'b0001, 1'b0, "restart");
        chk("restart points zeroed", int'(total_points), 0);
        chk("restart flicks zeroed", int'(light_flicks), 0);
        for (int i = 0; i < 25; i++)
            window(4'(i), 1'b1);
        chk("full points", int'(total_points), 25);
        chk("full flicks", int'(light_flicks), 25);
        chk("full still PLAY", int'(state), 1);
        tick();
        chk("full GAME_OVER", int'(state), 2);
        chk("full game_over", int'(game_over), 1);
        chk("full start_game low", int'(start_game), 0);
        window(4'd3, 1'b1);
        chk("game_over key ignored", int'(total_points), 25);
        chk("game_over flicks frozen", int'(light_flicks), 25);

        // Deathmatch: one missed window costs the only life.
        start_new(4'b0100, 1'b0, "dm");
        chk("dm lives start", int'(lives_left), 1);
        window(4'd8, 1'b0);
        chk("dm lives after miss", int'(lives_left), 0);
        chk("dm flicks", int'(light_flicks), 1);
        chk("dm points", int'(total_points), 0);
        tick();
        chk("dm GAME_OVER", int'(state), 2);

        // Timed: time_up after three hits.
        start_new(4'b0010, 1'b1, "timed");
        chk("timed max_hits ext", int'(max_hits), 50);
        chk("timed lives", int'(lives_left), 0);
        for (int i = 0; i < 3; i++)
            window(4'(i + 1), 1'b1);
        chk("timed points before", int'(total_points), 3);
        time_up = 1'b1;
        wait_state(2'd2, 3, "timed GAME_OVER");
        window(4'd2, 1'b1);
        chk("timed points frozen", int'(total_points), 3);
        time_up = 1'b0;

        // Continuity: level follows flicks / 10, capped at level 3.
        start_new(4'b1000, 1'b1, "cont");
        tick();
        chk("cont level 0", int'(level_diff), 1);
        for (int n = 1; n <= 35; n++) begin
            light_active = 1'b1;
            light_coord  = 4'd6;
            tick();
            light_active = 1'b0;
            tick();
            if (n == 10)
                chk("cont level lags at 10", int'(level_diff), 1);
            if (n == 30)
                chk("cont level lags at 30", int'(level_diff), 4);
            tick();
            chk($sformatf("cont level after %0d", n), int'(level_diff),
                (n < 10) ? 1 : (n < 20) ? 2 : (n < 30) ? 4 : 8);
        end
        chk("cont flicks", int'(light_flicks), 35);
        chk("cont still PLAY", int'(state), 1);

        // Deathmatch: key on the falling-edge cycle is a hit, no life lost.
        start_new(4'b0100, 1'b0, "edge");
        light_active = 1'b1;
        light_coord  = 4'd6;
        tick();
        light_active = 1'b0;
        key_valid    = 1'b1;
        key_code     = 4'd6;
        tick();
        key_valid = 1'b0;
        chk("edge hit points", int'(total_points), 1);
        chk("edge flicks", int'(light_flicks), 1);
        chk("edge lives kept", int'(lives_left), 1);
        tick();
        chk("edge stays PLAY", int'(state), 1);

        // Asynchronous reset away from any clock edge.
        #2;
        reset = 1'b0;
        #1;
        chk("async reset state", int'(state), 0);
        chk("async reset points", int'(total_points), 0);
        chk("async reset lives", int'(lives_left), 0);
        chk("async reset load_seed", int'(load_seed), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wam_game_controller.md
Name: wam_game_controller

Overview:
- Sequencing and scoring controller for the whack-a-mole game. It owns the game FSM (SETUP/PLAY/GAME_OVER/RESTART) and drives load_seed, start_game and the active-low clear to the light controller, keypad controller and countdown.
- Scores keypad hits against the lit position, once per light window. Counts flicks, misses and lives, and raises game_over.
- Sits between the player inputs/switches and the light, keypad and HEX-display datapath.

Parameters:
- NORMAL_HITS, 25, flicks per game when ext_game=0
- EXT_HITS, 50, flicks per game when ext_game=1
- DM_LIVES, 1, lives in deathmatch mode (2-bit)
- LEVEL_STEP, 10, flicks per level advance in continuity mode

Ports:
- clk  in  1  system clock (CLOCK_50)
- reset  in  1  asynchronous, active-low; all state cleared while 0
- play  in  1  level from debounced start button (active-high); internally edge-detected
- gamemode  in  4  one-hot: 0001 normal, 0010 timed, 0100 deathmatch, 1000 continuity; any other value = normal
- difficulty  in  4  one-hot level from switches; passed through except in continuity mode
- ext_game  in  1  0 selects NORMAL_HITS, 1 selects EXT_HITS
- light_active  in  1  high while a light is lit
- light_coord  in  4  key code of the lit position; valid while light_active=1
- key_valid  in  1  1-cycle pulse per accepted keypress
- key_code  in  4  pressed key; valid with key_valid
- time_up  in  1  countdown expired (timed mode)
- load_seed  out  1  LFSR seed load strobe
- start_game  out  1  high in PLAY
- clear_n  out  1  active-low datapath clear, 0 in RESTART
- state  out  2  0 SETUP, 1 PLAY, 2 GAME_OVER, 3 RESTART
- total_points  out  6  correct hits
- light_flicks  out  6  completed light windows
- max_hits  out  6  NORMAL_HITS or EXT_HITS as latched
- lives_left  out  2  remaining lives; 0 outside deathmatch
- level_diff  out  4  one-hot difficulty to the light controller
- game_over  out  1  high in GAME_OVER

Behaviour:
- Reset values: state=SETUP, all counters=0, lives_left=0, level_diff=0010, game_over=0, start_game=0, load_seed=1 (SETUP decode), clear_n=1.
- play_rise is registered play AND NOT previous play. All FSM reactions occur 1 cycle after play rises.
- SETUP: load_seed=1. On play_rise go to RESTART, so the first game starts from a cleared datapath.
- RESTART (exactly 1 cycle): clear_n=0. Zero points, flicks and level. Latch gamemode, ext_game and difficulty. lives_left=DM_LIVES if deathmatch, else 0. Always go to PLAY.
- PLAY: start_game=1.
  - play_rise goes to RESTART.
  - Else game-over condition goes to GAME_OVER.
  - play_rise has priority over the game-over condition in the same cycle.
- GAME_OVER: counters frozen, game_over=1. play_rise goes to RESTART.
- Game-over condition (evaluated on registered counters):
  - light_flicks == max_hits, or
  - deathmatch and lives_left == 0, or
  - timed and time_up.
- Window: opens on rising light_active and closes on falling light_active. A per-window hit_taken flag clears on open.
- Hit: key_valid while light_active, key_code == light_coord, and hit_taken=0. Result: total_points+1 (saturates at 63) and hit_taken set. Further keys in the same window are ignored.
- Wrong key or key with no light lit: no score change.
- Window close: light_flicks+1 (saturates at 63). If hit_taken=0 the window is a miss; in deathmatch lives_left-1, floored at 0.
- A hit and a close in the same cycle count as a hit; no miss is recorded.
- Inputs are ignored outside PLAY. A window still open on entering PLAY is only counted from its next open.
- Continuity mode:
  - level = min(light_flicks / LEVEL_STEP, 3).
  - level_diff = 0001 << level.
  - level_diff updates the cycle after the flick increment.
  - Other modes: level_diff = latched difficulty, or 0010 if the latched value is not one-hot.
- Async reset mid-game returns to SETUP immediately.

Optional Feature:
- WAM_STREAK_EN defined:
  - Adds output best_streak[5:0] and an internal cur_streak.
  - A hit increments cur_streak; a miss zeroes it.
  - best_streak = max(best_streak, cur_streak), updated each cycle.
  - Both are cleared in RESTART and by reset.
- Not defined: port and logic absent, no other behavioural change.

Decomposition:
- Package wam_pkg:
  - state encodings SETUP/PLAY/GAME_OVER/RESTART
  - gamemode one-hot constants
  - difficulty one-hot constants
  - default NORMAL_HITS/EXT_HITS
- Sub-module wam_window_tracker holds light_active edge detection, hit_taken, and the hit/miss/close pulses. The top holds the FSM, counters, lives and level logic.

Test Plan:
- Normal mode, ext_game=0, play pulse: expect SETUP→RESTART (clear_n=0 for 1 cycle)→PLAY. Drive 25 windows each with a correct key. Expect total_points=25, light_flicks=25, GAME_OVER on the next cycle.
- Within one window: correct key, then a second correct key, then a wrong key. Expect total_points increments once only.
- Deathmatch, DM_LIVES=1: one window with no key. On close expect lives_left 1→0, then GAME_OVER; light_flicks=1.
- Timed mode: assert time_up after 3 hits. Expect GAME_OVER with points=3. A key in GAME_OVER leaves points at 3.
- Continuity mode, LEVEL_STEP=10: 35 windows. Expect level_diff 0001 →(flick 10) 0010 → 0100 → (flick 30) 1000, holding 1000 afterwards.
- Correct key in the same cycle as light_active falls: expect a hit with no life lost. play pulse mid-PLAY: expect RESTART, counters zeroed, then PLAY.
